// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared arithmetic definitions for the serial arithmetic blocks.
//   state_t    : control FSM states (IDLE, RUN, DONE)
//   cnt_width  : bit-counter width for a given operand width (minimum 1)
//   fs_diff    : full-subtractor difference bit
//   fs_borrow  : full-subtractor borrow-out bit
// -----------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-bit counter is still needed when the operand is a single bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 32'd1) ? $clog2(width) : 32'd1;
    endfunction

    function automatic logic fs_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    // Borrow when the subtrahend bit wins outright, or when the operand bits
    // are equal and a borrow is already pending.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/fs_1bit.sv
// -----------------------------------------------------------------------------
// fs_1bit
// Combinational one-bit full subtractor: d = a - b - bin (mod 2), with borrow.
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow-in
//   d    out 1  difference bit
//   bout out 1  borrow-out
// -----------------------------------------------------------------------------
module fs_1bit
    import arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = fs_diff(a, b, bin);
    assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bit_serial_subtractor
// Computes a - b - bin one bit per clock, LSB first, through a single
// full-subtractor cell. Valid/ready handshake on both operand and result side.
//   WIDTH      param    operand/result width (>= 1)
//   clk        in  1    rising-edge clock
//   rst        in  1    asynchronous active-high reset
//   in_valid   in  1    operands valid
//   in_ready   out 1    block can accept operands (high only in IDLE)
//   a, b       in  W    minuend, subtrahend
//   bin        in  1    borrow-in
//   out_valid  out 1    diff/bout valid (high only in DONE)
//   out_ready  in  1    consumer accepts result
//   diff       out W    (a - b - bin) mod 2^WIDTH
//   bout       out 1    1 iff a < b + bin (unsigned)
// Latency is WIDTH cycles from the accept edge; initiation interval WIDTH+2.
// -----------------------------------------------------------------------------
module bit_serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_r;
    logic [WIDTH-1:0]   ra_r;
    logic [WIDTH-1:0]   rb_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   diff_r;
    logic               borrow_r;
    logic               bout_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               d_s;
    logic               bo_s;
    logic [WIDTH-1:0]   res_next_s;

    // Single shared bit cell working on the current LSBs and the running borrow.
    fs_1bit u_fs (
        .a    (ra_r[0]),
        .b    (rb_r[0]),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (bo_s)
    );

    // Result shifts right with the new bit entering at the MSB, so after WIDTH
    // steps the LSB-first bits sit in natural order.
    assign res_next_s = (res_r >> 1) | (WIDTH'(d_s) << (WIDTH - 1));

    // Control FSM with datapath registers; handshake outputs are registered
    // alongside the state so they depend on state only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ra_r        <= {WIDTH{1'b0}};
            rb_r        <= {WIDTH{1'b0}};
            res_r       <= {WIDTH{1'b0}};
            diff_r      <= {WIDTH{1'b0}};
            borrow_r    <= 1'b0;
            bout_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        ra_r       <= a;
                        rb_r       <= b;
                        borrow_r   <= bin;
                        res_r      <= {WIDTH{1'b0}};
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                RUN: begin
                    ra_r     <= ra_r >> 1;
                    rb_r     <= rb_r >> 1;
                    res_r    <= res_next_s;
                    borrow_r <= bo_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    // Output registers load only on the final bit, so a
                    // partial result is never visible on diff/bout.
                    if (cnt_r == LAST_CNT) begin
                        diff_r      <= res_next_s;
                        bout_r      <= bo_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r     <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign bout      = bout_r;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_subtractor
// Directed and exhaustive self-checking bench for bit_serial_subtractor
// (WIDTH = 4). Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] diff;
    logic       bout;

    int tests_run    = 0;
    int tests_failed = 0;

    // Independent 4-bit adder used to close the loop: diff + b + bin == a.
    logic [3:0] chk_diff;
    logic [3:0] chk_b;
    logic       chk_bin;
    logic [3:0] add_sum;
    assign add_sum = chk_diff + chk_b + {3'b000, chk_bin};

    bit_serial_subtractor #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One transaction: accept at the next rising edge, scramble the inputs
    // during RUN, wait for out_valid (bounded) and return result and latency.
    // With rdy set the result is consumed and the task returns in IDLE.
    task automatic op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                      input logic rdy, output logic [3:0] rd, output logic rb,
                      output int lat);
        @(negedge clk);
        check("pre_ready", in_ready, 1);
        a         = ta;
        b         = tb_v;
        bin       = tbin;
        in_valid  = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_v;
        bin      = ~tbin;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            a = 4'($urandom);
            b = 4'($urandom);
            @(negedge clk);
        end
        rd = diff;
        rb = bout;
        if (rdy) begin
            @(negedge clk);
        end
    endtask

    logic [3:0] rd;
    logic       rb;
    int         lat;
    int         q[$];
    int         idx;
    int         i_next;
    int         results;
    int         last_ov;
    logic [4:0] exp5;
    logic [8:0] vec;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 4'd0;
        b         = 4'd0;
        bin       = 1'b0;
        chk_diff  = 4'd0;
        chk_b     = 4'd0;
        chk_bin   = 1'b0;

        // Reset state.
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic directed vectors.
        op(4'd5, 4'd3, 1'b0, 1'b1, rd, rb, lat);
        check("5-3 diff", rd, 2);
        check("5-3 bout", rb, 0);
        check("5-3 latency", lat, 4);
        check("idle_after", in_ready, 1);
        check("idle_ov", out_valid, 0);

        op(4'd3, 4'd5, 1'b0, 1'b1, rd, rb, lat);
        check("3-5 diff", rd, 14);
        check("3-5 bout", rb, 1);

        op(4'd0, 4'd0, 1'b1, 1'b1, rd, rb, lat);
        check("0-0-1 diff", rd, 15);
        check("0-0-1 bout", rb, 1);

        // Exhaustive streaming with in_valid and out_ready held high.
        i_next  = 0;
        results = 0;
        last_ov = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 4000 && results < 512; k++) begin
            if (out_valid) begin
                idx  = q.pop_front();
                vec  = idx[8:0];
                exp5 = {1'b0, vec[8:5]} - {1'b0, vec[4:1]} - {4'b0000, vec[0]};
                check("stream_sub", {bout, diff}, exp5);
                chk_diff = diff;
                chk_b    = vec[4:1];
                chk_bin  = vec[0];
                #1;
                check("stream_add", add_sum, vec[8:5]);
                if (results > 0) begin
                    check("stream_ii", k - last_ov, 6);
                end
                last_ov = k;
                results++;
            end
            if (in_ready) begin
                if (i_next < 512) begin
                    vec      = i_next[8:0];
                    a        = vec[8:5];
                    b        = vec[4:1];
                    bin      = vec[0];
                    in_valid = 1'b1;
                    q.push_back(i_next);
                    i_next++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_count", results, 512);

        // Backpressure: result held while out_ready is low, in_valid ignored.
        op(4'd9, 4'd4, 1'b0, 1'b0, rd, rb, lat);
        check("bp latency", lat, 4);
        for (int j = 0; j < 10; j++) begin
            in_valid = j[0];
            a        = 4'(j);
            b        = 4'd1;
            check("bp_out_valid", out_valid, 1);
            check("bp_diff", diff, 5);
            check("bp_bout", bout, 0);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        check("bp_release_ov", out_valid, 0);

        // Reset in the middle of RUN, between clock edges.
        a        = 4'd15;
        b        = 4'd1;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_bout", bout, 0);
        @(negedge clk);
        rst = 1'b0;
        op(4'd7, 4'd7, 1'b0, 1'b1, rd, rb, lat);
        check("7-7 diff", rd, 0);
        check("7-7 bout", rb, 0);
        check("7-7 latency", lat, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
